// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input, decode handshake and fault status.
interface fetch_if;
   logic        fetch_enable;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instruction;
   logic        misaligned_fault;
   logic [31:0] fault_pc;

   modport master (
      input  fetch_enable, imem_data, redirect_valid, redirect_pc, out_ready,
      output imem_addr, out_valid, out_pc, out_instruction, misaligned_fault, fault_pc
   );

   modport slave (
      output fetch_enable, imem_data, redirect_valid, redirect_pc, out_ready,
      input  imem_addr, out_valid, out_pc, out_instruction, misaligned_fault, fault_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers the fetched word toward decode, handles redirects.
// Optional misaligned-redirect fault tracking is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned PC_STEP      = 4
) (
   input  logic     clk,
   input  logic     reset,
   fetch_if.master  bus
);

`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] opc_q, opc_d;
   logic [31:0] inst_q, inst_d;
   logic        accept_c;

   assign accept_c = valid_q && bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         opc_q   <= 32'h0;
         inst_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         opc_q   <= opc_d;
         inst_q  <= inst_d;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fault_q, fault_d;
   logic [31:0] fpc_q, fpc_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q <= 1'b0;
         fpc_q   <= 32'h0;
      end else begin
         fault_q <= fault_d;
         fpc_q   <= fpc_d;
      end
   end

   assign bus.misaligned_fault = fault_q;
   assign bus.fault_pc         = fpc_q;
`else
   assign bus.misaligned_fault = 1'b0;
   assign bus.fault_pc         = 32'h0;
`endif

   // Next-state: redirect overrides everything, otherwise load/stall/drain per state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      opc_d   = opc_q;
      inst_d  = inst_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d = fault_q;
      fpc_d   = fpc_q;
`endif
      if (bus.redirect_valid) begin
         valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         pc_d = bus.redirect_pc;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = bus.redirect_pc;
         end else if (state_q == FAULT) begin
            state_d = RUN;
            fault_d = 1'b0;
            fpc_d   = 32'h0;
         end else begin
            state_d = bus.fetch_enable ? RUN : IDLE;
         end
`else
         pc_d    = bus.redirect_pc & ~32'h3;
         state_d = bus.fetch_enable ? RUN : IDLE;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.fetch_enable) state_d = RUN;
               if (accept_c)         valid_d = 1'b0;
            end
            RUN: begin
               if (!bus.fetch_enable) begin
                  state_d = IDLE;
                  if (accept_c) valid_d = 1'b0;
               end else if (!valid_q || bus.out_ready) begin
                  opc_d   = pc_q;
                  inst_d  = bus.imem_data;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 32'(PC_STEP);
               end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            FAULT: begin
               if (accept_c) valid_d = 1'b0;
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.imem_addr       = pc_q;
   assign bus.out_valid       = valid_q;
   assign bus.out_pc          = opc_q;
   assign bus.out_instruction = inst_q;

endmodule
